hardwired_control_unit: RTL and testbench
=========================================

Name: hardwired_control_unit

Overview:
- Moore control FSM that generates, every cycle, the control strobes the System datapath consumes: out/in selects, Gra/Grb/Grc, ALU opcode, memory enables, IncPC, CONin. Bench-driven sequencing is replaced by this block.
- Sits beside the datapath inside System. Takes IR and con_ff_bit from the datapath and drives every datapath control input.
- Executes the shared fetch (T0–T2) followed by a per-opcode execute sequence (T3…T7), then returns to T0.

Parameters:
- DATA_WIDTH, 32, IR width.
- OPCODE_W, 5, opcode field width, located at IR[31:27].

Ports:
- Clock  in  1  single system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  DATA_WIDTH  instruction register contents from the datapath.
- con_ff_bit  in  1  branch condition flip-flop output.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  out  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in  out  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and enable.
- opcode  out  5  ALU operation.
- IncPC  out  1  PC increment enable.
- Mem_Read, Mem_Write, Mem_enable512x32  out  1 each  memory controls.
- run  out  1  high while executing; low after halt.

Behaviour:
- Reset: clear low forces state RESET asynchronously. All outputs are 0 and run is 1.
  - The first rising edge after clear goes high enters T0.
  - Reset asserted mid-instruction aborts it immediately, with no partial strobes.
- Outputs are a pure decode of the registered state plus IR and con_ff_bit. They are never a function of asynchronous inputs other than clear.
- opcode defaults to ADD (00011) outside ALU states. Every unlisted strobe is 0.
- Fetch, common to all instructions:
  - T0: PCout, IncPC, MARin, Zin.
  - T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32. Memory read latency is 1 cycle.
  - T2: MDRout, IRin.
  - T3 decodes IR[31:27], which is valid from T3 onward.
- Execute sequences. Each sequence's last state returns to T0.
  - add 00011, sub 00100, and 00101, or 00110:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, opcode=IR[31:27].
    - T5: Zlo_out, Gra, Rin.
  - addi 01100, andi 01101, ori 01110:
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, opcode = ADD / AND / OR respectively.
    - T5: Zlo_out, Gra, Rin.
  - ldi 00001:
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, opcode=ADD.
    - T5: Zlo_out, Gra, Rin.
  - ld 00000:
    - T3–T4 as ldi.
    - T5: Zlo_out, MARin.
    - T6: MDRin, Mem_Read, Mem_enable512x32.
    - T7: MDRout, Gra, Rin.
  - st 00010:
    - T3–T5 as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Mem_Write, Mem_enable512x32.
  - br 10010:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin, opcode=ADD.
    - T6: Zlo_out, PCin=con_ff_bit. Sampled combinationally in T6.
  - jr 10100:
    - T3: Gra, Rout, PCin.
  - jal 10101:
    - T3: PCout, Grb, Rin. This links the return PC into R[rb], which is R15 by convention.
    - T4: Gra, Rout, PCin.
  - in 10110: T3: Inport_out, Gra, Rin.
  - out 10111: T3: Gra, Rout, outport_in.
  - mfhi 11000: T3: HIout, Gra, Rin.
  - mflo 11001: T3: LOout, Gra, Rin.
  - nop 11010, and any unassigned opcode: T3 with no strobes, then T0.
- halt 11011: T3 → HALT. HALT holds forever with all strobes 0 and run=0. Only clear exits HALT.
- Invariants:
  - PCin never coincides with IncPC.
  - At most one bus source select is high in any state.
  - Mem_Read and Mem_Write are never both high.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams, the full list above;
  - the state encoding (RESET, T0–T7, HALT);
  - ALU_ADD/AND/OR constants.
- The FSM (state register plus next-state logic) and the output decode fit in one module.
- An optional combinational sub-module ctrl_opcode_decode maps IR[31:27] to an instruction class and a sequence length.

Test Plan:
- Reset: clear low for 3 cycles mid-ld T4.
  - Every output 0 within the same cycle.
  - After release, T0 shows PCout=IncPC=MARin=Zin=1.
- ldi r6,3: IR=0x0B000003.
  - T3 has Grb, BAout, Yin; T4 has Cout, Zin, opcode=00011; T5 has Zlo_out, Gra, Rin.
  - The next cycle is T0; total 6 cycles.
- jr r6: IR=0xA3000000.
  - T3 has Gra, Rout, PCin, and MARin=0.
  - Next cycle is T0 (4 cycles total).
- jal r6,r15: IR=0xAB780000.
  - T3 has PCout, Grb, Rin; T4 has Gra, Rout, PCin.
  - 5 cycles total.
- br: run with con_ff_bit=0, then with con_ff_bit=1.
  - T6 PCin is 0 and 1 respectively; Zlo_out=1 in both.
  - 7 cycles total.
- halt: IR=0xD8000000.
  - run falls after T3; PCout stays 0 for 20 cycles.
  - clear pulse restarts at T0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// FSM state encoding, instruction classes and the packed control word.
package ctrl_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int OPCODE_W   = 5;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD = 5'b00011;
   localparam logic [4:0] ALU_AND = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;

   typedef enum logic [3:0] {
      ST_RESET = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_T7    = 4'd8,
      ST_HALT  = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU  = 4'd0,
      CL_ALUI = 4'd1,
      CL_LDI  = 4'd2,
      CL_LD   = 4'd3,
      CL_ST   = 4'd4,
      CL_BR   = 4'd5,
      CL_JR   = 4'd6,
      CL_JAL  = 4'd7,
      CL_IN   = 4'd8,
      CL_OUT  = 4'd9,
      CL_MFHI = 4'd10,
      CL_MFLO = 4'd11,
      CL_NOP  = 4'd12,
      CL_HALT = 4'd13
   } iclass_t;

   typedef struct packed {
      logic       hi_out;
      logic       lo_out;
      logic       zhi_out;
      logic       zlo_out;
      logic       pc_out;
      logic       mdr_out;
      logic       inport_out;
      logic       c_out;
      logic       mar_in;
      logic       z_in;
      logic       pc_in;
      logic       mdr_in;
      logic       ir_in;
      logic       y_in;
      logic       hi_in;
      logic       lo_in;
      logic       con_in;
      logic       outport_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic [4:0] opcode;
      logic       inc_pc;
      logic       mem_read;
      logic       mem_write;
      logic       mem_enable;
      logic       run;
   } ctrl_t;

   // ALU operation for the immediate-form instructions
   function automatic logic [4:0] alu_imm_op(input logic [4:0] op);
      logic [4:0] res;
      case (op)
         OP_ANDI: res = ALU_AND;
         OP_ORI:  res = ALU_OR;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Maps the instruction opcode to an execute class and the index of the
// last T-state of its execute sequence (3..7).
module ctrl_opcode_decode
   import ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] op,
   output iclass_t             cls,
   output logic [2:0]          last_t
);

   // Classify the opcode; anything unassigned behaves as nop
   always_comb begin
      cls    = CL_NOP;
      last_t = 3'd3;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin cls = CL_ALU;  last_t = 3'd5; end
         OP_ADDI, OP_ANDI, OP_ORI:      begin cls = CL_ALUI; last_t = 3'd5; end
         OP_LDI:  begin cls = CL_LDI;  last_t = 3'd5; end
         OP_LD:   begin cls = CL_LD;   last_t = 3'd7; end
         OP_ST:   begin cls = CL_ST;   last_t = 3'd7; end
         OP_BR:   begin cls = CL_BR;   last_t = 3'd6; end
         OP_JR:   begin cls = CL_JR;   last_t = 3'd3; end
         OP_JAL:  begin cls = CL_JAL;  last_t = 3'd4; end
         OP_IN:   begin cls = CL_IN;   last_t = 3'd3; end
         OP_OUT:  begin cls = CL_OUT;  last_t = 3'd3; end
         OP_MFHI: begin cls = CL_MFHI; last_t = 3'd3; end
         OP_MFLO: begin cls = CL_MFLO; last_t = 3'd3; end
         OP_HALT: begin cls = CL_HALT; last_t = 3'd3; end
         default: begin cls = CL_NOP;  last_t = 3'd3; end
      endcase
   end

endmodule

// File: rtl/hardwired_control_unit.sv
// Moore control FSM driving every datapath strobe: shared fetch T0-T2,
// per-opcode execute T3..T7, and a sticky HALT state left only by clear.
module hardwired_control_unit
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] IR,
   input  logic                  con_ff_bit,
   output logic HIout, output logic LOout, output logic Zhi_out, output logic Zlo_out,
   output logic PCout, output logic MDRout, output logic Inport_out, output logic Cout,
   output logic MARin, output logic Zin, output logic PCin, output logic MDRin,
   output logic IRin, output logic Yin, output logic HIin, output logic LOin,
   output logic CONin, output logic outport_in,
   output logic Gra, output logic Grb, output logic Grc,
   output logic Rin, output logic Rout, output logic BAout,
   output logic [4:0] opcode,
   output logic IncPC,
   output logic Mem_Read, output logic Mem_Write, output logic Mem_enable512x32,
   output logic run
);

   state_t        state_r;
   state_t        next_state_s;
   iclass_t       cls_s;
   logic [2:0]    last_t_s;
   logic [4:0]    ir_op_s;
   ctrl_t         ctrl_s;
   logic          unused_ir_s;

   assign ir_op_s     = IR[DATA_WIDTH-1 -: OPCODE_W];
   assign unused_ir_s = ^IR[DATA_WIDTH-OPCODE_W-1:0];

   ctrl_opcode_decode u_decode (
      .op     (ir_op_s),
      .cls    (cls_s),
      .last_t (last_t_s)
   );

   // State register; clear aborts any instruction immediately
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state: fetch chain, then leave at the class's last T-state
   always_comb begin
      next_state_s = ST_RESET;
      case (state_r)
         ST_RESET: next_state_s = ST_T0;
         ST_T0:    next_state_s = ST_T1;
         ST_T1:    next_state_s = ST_T2;
         ST_T2:    next_state_s = ST_T3;
         ST_T3: begin
            if (cls_s == CL_HALT) begin
               next_state_s = ST_HALT;
            end else if (last_t_s == 3'd3) begin
               next_state_s = ST_T0;
            end else begin
               next_state_s = ST_T4;
            end
         end
         ST_T4:    next_state_s = (last_t_s == 3'd4) ? ST_T0 : ST_T5;
         ST_T5:    next_state_s = (last_t_s == 3'd5) ? ST_T0 : ST_T6;
         ST_T6:    next_state_s = (last_t_s == 3'd6) ? ST_T0 : ST_T7;
         ST_T7:    next_state_s = ST_T0;
         ST_HALT:  next_state_s = ST_HALT;
         default:  next_state_s = ST_RESET;
      endcase
   end

   // Output decode of the registered state (plus IR class and con_ff_bit)
   always_comb begin
      ctrl_s        = '0;
      ctrl_s.opcode = ALU_ADD;
      ctrl_s.run    = 1'b1;
      case (state_r)
         ST_RESET: ctrl_s.opcode = 5'b00000;
         ST_T0: begin
            ctrl_s.pc_out = 1'b1; ctrl_s.inc_pc = 1'b1; ctrl_s.mar_in = 1'b1; ctrl_s.z_in = 1'b1;
         end
         ST_T1: begin
            ctrl_s.zlo_out = 1'b1; ctrl_s.pc_in = 1'b1; ctrl_s.mdr_in = 1'b1;
            ctrl_s.mem_read = 1'b1; ctrl_s.mem_enable = 1'b1;
         end
         ST_T2: begin
            ctrl_s.mdr_out = 1'b1; ctrl_s.ir_in = 1'b1;
         end
         ST_T3: begin
            case (cls_s)
               CL_ALU, CL_ALUI:      begin ctrl_s.grb = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.y_in = 1'b1; end
               CL_LDI, CL_LD, CL_ST: begin ctrl_s.grb = 1'b1; ctrl_s.ba_out = 1'b1; ctrl_s.y_in = 1'b1; end
               CL_BR:   begin ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.con_in = 1'b1; end
               CL_JR:   begin ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.pc_in = 1'b1; end
               CL_JAL:  begin ctrl_s.pc_out = 1'b1; ctrl_s.grb = 1'b1; ctrl_s.r_in = 1'b1; end
               CL_IN:   begin ctrl_s.inport_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1; end
               CL_OUT:  begin ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.outport_in = 1'b1; end
               CL_MFHI: begin ctrl_s.hi_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1; end
               CL_MFLO: begin ctrl_s.lo_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1; end
               default: begin end
            endcase
         end
         ST_T4: begin
            case (cls_s)
               CL_ALU:  begin ctrl_s.grc = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.z_in = 1'b1; ctrl_s.opcode = ir_op_s; end
               CL_ALUI: begin ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1; ctrl_s.opcode = alu_imm_op(ir_op_s); end
               CL_LDI, CL_LD, CL_ST: begin ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1; end
               CL_BR:   begin ctrl_s.pc_out = 1'b1; ctrl_s.y_in = 1'b1; end
               CL_JAL:  begin ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.pc_in = 1'b1; end
               default: begin end
            endcase
         end
         ST_T5: begin
            case (cls_s)
               CL_ALU, CL_ALUI, CL_LDI: begin ctrl_s.zlo_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1; end
               CL_LD, CL_ST: begin ctrl_s.zlo_out = 1'b1; ctrl_s.mar_in = 1'b1; end
               CL_BR:        begin ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1; end
               default: begin end
            endcase
         end
         ST_T6: begin
            case (cls_s)
               CL_LD: begin ctrl_s.mdr_in = 1'b1; ctrl_s.mem_read = 1'b1; ctrl_s.mem_enable = 1'b1; end
               CL_ST: begin ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.mdr_in = 1'b1; end
               CL_BR: begin ctrl_s.zlo_out = 1'b1; ctrl_s.pc_in = con_ff_bit; end
               default: begin end
            endcase
         end
         ST_T7: begin
            case (cls_s)
               CL_LD: begin ctrl_s.mdr_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1; end
               CL_ST: begin ctrl_s.mem_write = 1'b1; ctrl_s.mem_enable = 1'b1; end
               default: begin end
            endcase
         end
         ST_HALT: ctrl_s.run = 1'b0;
         default: ctrl_s.opcode = 5'b00000;
      endcase
   end

   assign HIout = ctrl_s.hi_out;         assign LOout = ctrl_s.lo_out;
   assign Zhi_out = ctrl_s.zhi_out;      assign Zlo_out = ctrl_s.zlo_out;
   assign PCout = ctrl_s.pc_out;         assign MDRout = ctrl_s.mdr_out;
   assign Inport_out = ctrl_s.inport_out; assign Cout = ctrl_s.c_out;
   assign MARin = ctrl_s.mar_in;         assign Zin = ctrl_s.z_in;
   assign PCin = ctrl_s.pc_in;           assign MDRin = ctrl_s.mdr_in;
   assign IRin = ctrl_s.ir_in;           assign Yin = ctrl_s.y_in;
   assign HIin = ctrl_s.hi_in;           assign LOin = ctrl_s.lo_in;
   assign CONin = ctrl_s.con_in;         assign outport_in = ctrl_s.outport_in;
   assign Gra = ctrl_s.gra;              assign Grb = ctrl_s.grb;
   assign Grc = ctrl_s.grc;              assign Rin = ctrl_s.r_in;
   assign Rout = ctrl_s.r_out;           assign BAout = ctrl_s.ba_out;
   assign opcode = ctrl_s.opcode;        assign IncPC = ctrl_s.inc_pc;
   assign Mem_Read = ctrl_s.mem_read;    assign Mem_Write = ctrl_s.mem_write;
   assign Mem_enable512x32 = ctrl_s.mem_enable;
   assign run = ctrl_s.run;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Self-checking bench: per-instruction expected strobe sequences are built
// from the instruction-level rules and compared cycle by cycle.
module tb_hardwired_control_unit;

   logic        Clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        con_ff_bit;
   logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
   logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Mem_Read, Mem_Write, Mem_enable512x32, run;
   logic [4:0] opcode;

   hardwired_control_unit #(.DATA_WIDTH(32)) dut (
      .Clock(Clock), .clear(clear), .IR(IR), .con_ff_bit(con_ff_bit),
      .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
      .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .opcode(opcode), .IncPC(IncPC), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
      .Mem_enable512x32(Mem_enable512x32), .run(run)
   );

   always #5 Clock = ~Clock;

   // Strobe bit positions within the 28-bit strobe field
   localparam int HI_O = 27, LO_O = 26, ZHI_O = 25, ZLO_O = 24, PC_O = 23, MDR_O = 22, INP_O = 21, C_O = 20;
   localparam int MAR_I = 19, Z_I = 18, PC_I = 17, MDR_I = 16, IR_I = 15, Y_I = 14, HI_I = 13, LO_I = 12;
   localparam int CON_I = 11, OUTP_I = 10, GRA = 9, GRB = 8, GRC = 7, R_IN = 6, R_OUT = 5, BA_O = 4;
   localparam int INC = 3, MRD = 2, MWR = 1, MEN = 0;

   typedef struct packed {
      logic [27:0] s;
      logic [4:0]  op;
      logic        run;
   } exp_t;

   localparam logic [33:0] RESET_V = {28'd0, 5'b00000, 1'b1};
   localparam logic [33:0] HALT_V  = {28'd0, 5'b00011, 1'b0};

   logic [33:0] obs;
   assign obs = {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
                 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                 Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Mem_Read, Mem_Write, Mem_enable512x32,
                 opcode, run};

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_value(input string tag, input logic [33:0] got, input logic [33:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (strobes/opcode/run)", tag, got, want);
      end
   endtask

   function automatic logic [27:0] mk(input int a = -1, input int b = -1, input int c = -1,
                                      input int d = -1, input int e = -1);
      logic [27:0] m;
      m = 28'd0;
      if (a >= 0) m[a] = 1'b1;
      if (b >= 0) m[b] = 1'b1;
      if (c >= 0) m[c] = 1'b1;
      if (d >= 0) m[d] = 1'b1;
      if (e >= 0) m[e] = 1'b1;
      return m;
   endfunction

   task automatic push(input logic [27:0] s, input logic [4:0] op = 5'b00011);
      exp_t e;
      e.s = s; e.op = op; e.run = 1'b1;
      exp_q.push_back(e);
   endtask

   // Reference: fetch followed by the execute steps of one instruction
   task automatic build_seq(input logic [4:0] op, input logic con);
      exp_q.delete();
      push(mk(PC_O, INC, MAR_I, Z_I));
      push(mk(ZLO_O, PC_I, MDR_I, MRD, MEN));
      push(mk(MDR_O, IR_I));
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
            push(mk(GRB, R_OUT, Y_I)); push(mk(GRC, R_OUT, Z_I), op); push(mk(ZLO_O, GRA, R_IN));
         end
         5'b01100, 5'b01101, 5'b01110: begin
            push(mk(GRB, R_OUT, Y_I));
            push(mk(C_O, Z_I), (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110);
            push(mk(ZLO_O, GRA, R_IN));
         end
         5'b00001: begin
            push(mk(GRB, BA_O, Y_I)); push(mk(C_O, Z_I)); push(mk(ZLO_O, GRA, R_IN));
         end
         5'b00000: begin
            push(mk(GRB, BA_O, Y_I)); push(mk(C_O, Z_I)); push(mk(ZLO_O, MAR_I));
            push(mk(MDR_I, MRD, MEN)); push(mk(MDR_O, GRA, R_IN));
         end
         5'b00010: begin
            push(mk(GRB, BA_O, Y_I)); push(mk(C_O, Z_I)); push(mk(ZLO_O, MAR_I));
            push(mk(GRA, R_OUT, MDR_I)); push(mk(MWR, MEN));
         end
         5'b10010: begin
            push(mk(GRA, R_OUT, CON_I)); push(mk(PC_O, Y_I)); push(mk(C_O, Z_I));
            push(con ? mk(ZLO_O, PC_I) : mk(ZLO_O));
         end
         5'b10100: push(mk(GRA, R_OUT, PC_I));
         5'b10101: begin push(mk(PC_O, GRB, R_IN)); push(mk(GRA, R_OUT, PC_I)); end
         5'b10110: push(mk(INP_O, GRA, R_IN));
         5'b10111: push(mk(GRA, R_OUT, OUTP_I));
         5'b11000: push(mk(HI_O, GRA, R_IN));
         5'b11001: push(mk(LO_O, GRA, R_IN));
         default:  push(mk());
      endcase
   endtask

   // Run one whole instruction starting in T0; ends in the next T0
   task automatic run_instr(input logic [31:0] ir, input logic con, input string tag);
      IR = ir;
      con_ff_bit = con;
      build_seq(ir[31:27], con);
      for (int i = 0; i < exp_q.size(); i++) begin
         check_value($sformatf("%s op=%b step%0d", tag, ir[31:27], i), obs, exp_q[i]);
         @(posedge Clock); #1;
      end
   endtask

   logic [4:0]  dir_ops [19] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101,
                                 5'b01110, 5'b00001, 5'b00000, 5'b00010, 5'b10010, 5'b10100,
                                 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010, 5'b01000};

   initial begin
      logic [31:0] r;
      logic [4:0]  op;
      clear = 1'b0; IR = 32'd0; con_ff_bit = 1'b0;
      #12;
      check_value("reset_state", obs, RESET_V);
      clear = 1'b1;
      @(posedge Clock); #1;

      run_instr(32'h0B000003, 1'b0, "ldi");
      run_instr(32'hA3000000, 1'b0, "jr");
      run_instr(32'hAB780000, 1'b0, "jal");
      run_instr(32'h90800000, 1'b0, "br_con0");
      run_instr(32'h90800000, 1'b1, "br_con1");

      for (int i = 0; i < 19; i++) begin
         r = $urandom();
         run_instr({dir_ops[i], r[26:0]}, r[27], "dir");
      end

      for (int i = 0; i < 60; i++) begin
         r  = $urandom();
         op = 5'($urandom_range(0, 31));
         if (op == 5'b11011) op = 5'b11010;
         run_instr({op, r[26:0]}, r[31], "rnd");
      end

      // ld interrupted by clear while in T4
      IR = 32'h00000000; con_ff_bit = 1'b0;
      build_seq(5'b00000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_value($sformatf("ld_abort step%0d", i), obs, exp_q[i]);
         if (i < 4) begin
            @(posedge Clock); #1;
         end
      end
      #2 clear = 1'b0;
      #1 check_value("abort_same_cycle", obs, RESET_V);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); #1;
         check_value($sformatf("abort_hold%0d", i), obs, RESET_V);
      end
      clear = 1'b1;
      @(posedge Clock); #1;
      run_instr(32'h0B000003, 1'b0, "after_abort");

      // halt: sticky until clear
      run_instr(32'hD8000000, 1'b0, "halt");
      for (int i = 0; i < 20; i++) begin
         check_value($sformatf("halt_hold%0d", i), obs, HALT_V);
         @(posedge Clock); #1;
      end
      #2 clear = 1'b0;
      #1 check_value("halt_clear", obs, RESET_V);
      @(posedge Clock); #1;
      clear = 1'b1;
      @(posedge Clock); #1;
      run_instr(32'hD0000000, 1'b0, "restart_nop");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
